// File: rtl/booth_mult16_pkg.sv
// Shared constants and types for the sequential radix-2 Booth multiplier.
// Holds the operand width, step count, FSM state encoding and Booth decode codes.
package booth_mult16_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_STEPS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult16_adder16.sv
// 16-bit adder with carry in/out used for the Booth accumulate step.
// Purely combinational; no flow control.
module adder16
  import booth_mult16_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] i_a,
  input  logic [MULT_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [MULT_WIDTH-1:0] o_sum,
  output logic                  o_cout
);

  logic [MULT_WIDTH:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{MULT_WIDTH{1'b0}}, i_cin};
  assign o_sum  = w_full[MULT_WIDTH-1:0];
  assign o_cout = w_full[MULT_WIDTH];

endmodule

// File: rtl/booth_mult16.sv
// Sequential signed 16x16 radix-2 Booth multiplier, one step per clock.
// Latency 16 cycles from the start edge; starts during RUN are ignored (no queueing).
module booth_mult16
  import booth_mult16_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int STEPS = MULT_STEPS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [2*WIDTH-1:0] data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               data_busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH:0]   r_p;
  logic [WIDTH-1:0]   r_m;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_exc;
  logic               r_rdy;

  logic [WIDTH-1:0]   w_u;
  logic [WIDTH-1:0]   w_l;
  logic               w_q1;
  logic [1:0]         w_code;
  logic               w_is_add;
  logic               w_is_sub;
  logic               w_do_op;
  logic [WIDTH-1:0]   w_bop;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_acc;
  logic               w_s;
  logic [2*WIDTH:0]   w_p_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_start;
  logic               w_last;

  assign w_u      = r_p[2*WIDTH:WIDTH+1];
  assign w_l      = r_p[WIDTH:1];
  assign w_q1     = r_p[0];
  assign w_code   = {w_l[0], w_q1};
  assign w_is_add = (w_code == BOOTH_ADD);
  assign w_is_sub = (w_code == BOOTH_SUB);
  assign w_do_op  = w_is_add | w_is_sub;
  assign w_bop    = w_is_sub ? ~r_m : r_m;

  adder16 u_adder16 (
    .i_a    (w_u),
    .i_b    (w_bop),
    .i_cin  (w_is_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The 17th sum bit keeps U-M correct even when M is the most-negative value.
  assign w_acc   = w_do_op ? w_sum : w_u;
  assign w_s     = w_do_op ? (w_u[WIDTH-1] ^ w_bop[WIDTH-1] ^ w_cout) : w_u[WIDTH-1];
  assign w_p_nxt = {w_s, w_acc, w_l};
  assign w_prod  = w_p_nxt[2*WIDTH:1];

  assign w_start = (r_state == IDLE) && ctrl_MULT;
  assign w_last  = (r_state == RUN) && (r_cnt == 5'(STEPS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ctrl_MULT) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_m   <= data_operandA;
        r_p   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_p   <= w_p_nxt;
        r_cnt <= r_cnt + 5'd1;
        if (w_last) begin
          r_result <= w_prod;
          r_exc    <= !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
          r_rdy    <= 1'b1;
        end
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign data_busy      = (r_state == RUN);

endmodule

// File: tb/tb_booth_mult16.sv
// Directed bench for booth_mult16: vector table plus busy, back-to-back and reset sequences.
module tb_booth_mult16;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [15:0] data_operandA;
  logic [15:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult16 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Start edge k is the rising edge between the two negedges; returns just after edge k.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = 16'($urandom);
    data_operandB = 16'($urandom);
  endtask

  task automatic wait_rdy(input int max_cycles, output int cyc);
    cyc = -1;
    for (int n = 1; n <= max_cycles; n++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        cyc = n;
        break;
      end
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] held;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
    vecs[1] = '{16'hFFF9, 16'h0006, 32'hFFFFFFD6, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 32'h40000000, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 32'hFFFF8000, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1};
    vecs[6] = '{16'h0100, 16'h0080, 32'h00008000, 1'b1};

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    check("reset_result", data_result, 32'h0);
    check("reset_exc",    32'(data_exception), 32'h0);
    check("reset_rdy",    32'(data_resultRDY), 32'h0);
    check("reset_busy",   32'(data_busy), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 32'(data_busy), 32'h1);
      wait_rdy(24, cyc);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'd16);
      check($sformatf("v%0d_result", i), data_result, vecs[i].res);
      check($sformatf("v%0d_exc", i), 32'(data_exception), 32'(vecs[i].exc));
      check($sformatf("v%0d_busy_at_rdy", i), 32'(data_busy), 32'h0);
      @(negedge clock);
      check($sformatf("v%0d_rdy_drop", i), 32'(data_resultRDY), 32'h0);
      check($sformatf("v%0d_hold", i), data_result, vecs[i].res);
    end

    // Start during RUN is ignored; start in the RDY cycle is accepted.
    do_start(16'd2, 16'd3);
    repeat (4) @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 16'd9;
    data_operandB = 16'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("b2b_busy_after_ignored", 32'(data_busy), 32'h1);
    wait_rdy(24, cyc);
    check("b2b_first_latency", 32'(cyc), 32'd11);
    check("b2b_first_result", data_result, 32'h00000006);
    ctrl_MULT     = 1'b1;
    data_operandA = 16'd4;
    data_operandB = 16'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("b2b_second_busy", 32'(data_busy), 32'h1);
    check("b2b_second_rdy_low", 32'(data_resultRDY), 32'h0);
    held = data_result;
    check("b2b_hold_during_run", held, 32'h00000006);
    wait_rdy(24, cyc);
    check("b2b_second_latency", 32'(cyc), 32'd16);
    check("b2b_second_result", data_result, 32'h00000010);

    // Asynchronous reset mid-operation.
    do_start(16'd100, 16'd100);
    repeat (7) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_result", data_result, 32'h0);
    check("rst_mid_exc",    32'(data_exception), 32'h0);
    check("rst_mid_rdy",    32'(data_resultRDY), 32'h0);
    check("rst_mid_busy",   32'(data_busy), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    wait_rdy(20, cyc);
    check("rst_no_rdy", 32'(cyc), 32'hFFFFFFFF);
    do_start(16'd2, 16'd2);
    wait_rdy(24, cyc);
    check("post_rst_latency", 32'(cyc), 32'd16);
    check("post_rst_result", data_result, 32'h00000004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
